acl_tilt_filter: RTL and testbench
==================================

Name: acl_tilt_filter

Overview:
- Downstream consumer of the SPI accelerometer master. Takes each new 15-bit accelerometer word and extracts the signed tilt axis.
- Smooths that axis with a power-of-two moving average, then applies a dead-zone with hysteresis.
- Drives the left/right move signals and tilt_intensity for the VGA/game controller, and thermometer LED bars for the board.
- Replaces the raw per-sample tilt decode in the top level.

Parameters:
- AVG_LOG2, 2, log2 of moving-average window (window = 4 samples); legal 1..4
- ENTER_TH, 4, minimum |average| to enter a tilt state
- EXIT_TH, 2, |average| below which a tilt state returns to neutral; must be <= ENTER_TH

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- acl_data  in  15  accelerometer word from spi_master; tilt axis = acl_data[9:5], 5-bit two's complement
- acl_valid  in  1  one-cycle strobe: acl_data holds a new sample
- tilt_left  out  1  filtered tilt-left indication
- tilt_right  out  1  filtered tilt-right indication (negative axis = right)
- tilt_intensity  out  4  saturated |average|, 0 in neutral
- left_leds  out  4  thermometer bar of intensity when left, else 0
- right_leds  out  4  thermometer bar of intensity when right, else 0
- out_valid  out  1  one-cycle pulse when outputs reflect a newly processed sample

Behaviour:
- Clock and reset: single clock, clk. rst is synchronous and active-high and wins over acl_valid in the same cycle.
- Reset state: history buffer = 0, running sum = 0, write pointer = 0, state NEUTRAL. All outputs = 0.
- Stage 1 (cycle after acl_valid):
  - sample s = sign-extended acl_data[9:5], range -16..15
  - sum <= sum + s - buf[wp]; buf[wp] <= s; wp <= wp+1, wrapping modulo 2^AVG_LOG2
  - sum is signed, 5+AVG_LOG2 bits; it cannot overflow
- Stage 2 (next cycle):
  - avg = sum >>> AVG_LOG2 (arithmetic shift, rounds toward -inf); mag = |avg|
  - state update as below; outputs registered; out_valid pulses
  - total latency: acl_valid at cycle N, outputs and out_valid at N+2
- acl_valid on consecutive cycles: fully pipelined, one sample per cycle, no drops.
- No acl_valid: outputs hold their values.
- Warm-up: the buffer starts at zeros, so the average ramps up. No special warm-up handling.
- FSM (state changes only in stage 2):
  - NEUTRAL: avg <= -ENTER_TH -> RIGHT; avg >= ENTER_TH -> LEFT; else stay
  - RIGHT: avg >= ENTER_TH -> LEFT (direct flip); avg > -EXIT_TH -> NEUTRAL; else stay
  - LEFT: avg <= -ENTER_TH -> RIGHT (direct flip); avg < EXIT_TH -> NEUTRAL; else stay
- Output decode:
  - tilt_left = (state==LEFT); tilt_right = (state==RIGHT); never both high
  - tilt_intensity = min(mag,15) in LEFT/RIGHT, 0 in NEUTRAL; mag of 16 (avg -16) saturates to 15
  - thermometer bar = {i>=12, i>=8, i>=4, i>=1}, bit0 is LSB
  - bar is routed to left_leds or right_leds by state; the other output is 0
- Reset mid-operation: an in-flight stage-1 result is discarded, out_valid stays 0, and the next sample starts from an empty history.

Decomposition:
- Shared package: FSM state encoding (NEUTRAL=2'd0, LEFT=2'd1, RIGHT=2'd2); axis field constants ACL_AXIS_MSB=9, ACL_AXIS_LSB=5.
- One natural sub-module: acl_moving_avg (circular buffer + running sum, stage 1), instantiated by acl_tilt_filter, which keeps the hysteresis FSM and output decode.

Test Plan (defaults AVG_LOG2=2, ENTER_TH=4, EXIT_TH=2):
1. Assert rst for 2 cycles with acl_valid=1 and axis=-8 -> all outputs 0, out_valid 0, state NEUTRAL.
2. Four acl_valid pulses with axis=-8 (5'b11000):
   - avg sequence -2,-4,-6,-8
   - after 1st: neutral
   - after 2nd: tilt_right=1, intensity 4, right_leds 4'b0011
   - after 4th: intensity 8, right_leds 4'b0111
   - each out_valid exactly 2 cycles after its strobe
3. From step 2, feed axis=+4 one sample at a time:
   - avg -5 -> stays RIGHT; avg -2 -> stays RIGHT; avg +1 -> NEUTRAL (all 0)
   - avg +4 -> LEFT, intensity 4, left_leds 4'b0011
4. Hysteresis and direct flip:
   - from LEFT at avg +3: stays LEFT, intensity 3, left_leds 4'b0001
   - then four samples of -12: state goes LEFT -> NEUTRAL -> RIGHT without tilt_left and tilt_right ever both high
5. Saturation: four samples of -16 (5'b10000) -> avg -16, tilt_right=1, intensity 15, right_leds 4'b1111.
6. Back-to-back acl_valid for 6 cycles with alternating +15/-16 -> 6 out_valid pulses on consecutive cycles. Running sum matches the reference model every cycle.

Source files
------------

// File: rtl/acl_tilt_filter_pkg.sv
// Shared definitions for the accelerometer tilt filter.
//   tilt_state_t  : hysteresis FSM state encoding
//   ACL_AXIS_*    : location of the tilt axis inside the 15-bit accelerometer word
//   therm_bar()   : 4-bit thermometer bar for a 4-bit intensity
package acl_tilt_filter_pkg;

    typedef enum logic [1:0] {
        ST_NEUTRAL = 2'd0,
        ST_LEFT    = 2'd1,
        ST_RIGHT   = 2'd2
    } tilt_state_t;

    localparam int ACL_AXIS_MSB = 9;
    localparam int ACL_AXIS_LSB = 5;
    localparam int AXIS_W       = ACL_AXIS_MSB - ACL_AXIS_LSB + 1;

    // Bit k lights once the intensity reaches the k-th step (1, 4, 8, 12).
    function automatic logic [3:0] therm_bar(input logic [3:0] i);
        return {i >= 4'd12, i >= 4'd8, i >= 4'd4, i >= 4'd1};
    endfunction

endpackage

// File: rtl/acl_moving_avg.sv
// Stage 1 of the tilt filter: circular history of the last 2^AVG_LOG2 axis
// samples and their running sum.
//   clk, rst      : clock, synchronous active-high reset
//   sample_valid  : one-cycle strobe, sample holds a new axis value
//   sample        : signed axis sample
//   sum           : signed running sum of the history window
//   sum_valid     : one-cycle pulse, sum was updated by a new sample last edge
module acl_moving_avg
    import acl_tilt_filter_pkg::*;
#(
    parameter int AVG_LOG2 = 2
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               sample_valid,
    input  logic signed [AXIS_W-1:0]           sample,
    output logic signed [AXIS_W+AVG_LOG2-1:0]  sum,
    output logic                               sum_valid
);

    localparam int DEPTH = 1 << AVG_LOG2;
    localparam int SUM_W = AXIS_W + AVG_LOG2;

    logic signed [AXIS_W-1:0] hist_q [DEPTH];
    logic [AVG_LOG2-1:0]      wp_q;
    logic signed [SUM_W-1:0]  sum_q;
    logic                     valid_q;
    logic signed [AXIS_W-1:0] oldest;
    logic signed [SUM_W-1:0]  sample_ext;
    logic signed [SUM_W-1:0]  oldest_ext;

    assign oldest     = hist_q[wp_q];
    assign sample_ext = {{AVG_LOG2{sample[AXIS_W-1]}}, sample};
    assign oldest_ext = {{AVG_LOG2{oldest[AXIS_W-1]}}, oldest};

    // The sum always equals the sum of the window contents, so SUM_W bits
    // hold it without overflow. wp_q wraps naturally at its width.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                hist_q[i] <= '0;
            end
            wp_q    <= '0;
            sum_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= sample_valid;
            if (sample_valid) begin
                sum_q        <= sum_q + sample_ext - oldest_ext;
                hist_q[wp_q] <= sample;
                wp_q         <= wp_q + AVG_LOG2'(1);
            end
        end
    end

    assign sum       = sum_q;
    assign sum_valid = valid_q;

endmodule

// File: rtl/acl_tilt_filter.sv
// Accelerometer tilt filter: extracts the signed tilt axis from each new
// accelerometer word, smooths it with a 2^AVG_LOG2 moving average and applies
// a dead-zone with hysteresis to drive left/right tilt, intensity and LED bars.
//   clk, rst        : clock, synchronous active-high reset (wins over acl_valid)
//   acl_data        : accelerometer word, tilt axis in [9:5] (two's complement)
//   acl_valid       : one-cycle strobe, acl_data holds a new sample
//   tilt_left/right : filtered tilt state (negative axis = right)
//   tilt_intensity  : saturated |average|, 0 in neutral
//   left/right_leds : thermometer bar of intensity on the active side
//   out_valid       : one-cycle pulse, outputs reflect a newly processed sample
// Handshake: strobe-only, no back-pressure. Every acl_valid cycle is accepted
// and produces exactly one out_valid pulse two cycles later; outputs hold
// between pulses.
module acl_tilt_filter
    import acl_tilt_filter_pkg::*;
#(
    parameter int AVG_LOG2 = 2,  // legal 1..4
    parameter int ENTER_TH = 4,
    parameter int EXIT_TH  = 2   // must be <= ENTER_TH
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [14:0] acl_data,
    input  logic        acl_valid,
    output logic        tilt_left,
    output logic        tilt_right,
    output logic [3:0]  tilt_intensity,
    output logic [3:0]  left_leds,
    output logic [3:0]  right_leds,
    output logic        out_valid
);

    localparam int SUM_W = AXIS_W + AVG_LOG2;

    logic signed [AXIS_W-1:0] sample;
    logic signed [SUM_W-1:0]  sum;
    logic                     sum_valid;
    logic signed [SUM_W-1:0]  avg;
    int                       avg_i;
    int                       mag_i;
    logic [3:0]               mag_sat;
    tilt_state_t              state_q;
    tilt_state_t              state_d;

    assign sample = acl_data[ACL_AXIS_MSB:ACL_AXIS_LSB];

    acl_moving_avg #(
        .AVG_LOG2 (AVG_LOG2)
    ) u_avg (
        .clk          (clk),
        .rst          (rst),
        .sample_valid (acl_valid),
        .sample       (sample),
        .sum          (sum),
        .sum_valid    (sum_valid)
    );

    // Arithmetic shift: the average rounds toward minus infinity.
    assign avg = sum >>> AVG_LOG2;

    // Stage 2 next-state logic. The state only moves when a new sum arrives.
    always_comb begin
        avg_i   = int'(avg);
        mag_i   = (avg_i < 0) ? -avg_i : avg_i;
        mag_sat = (mag_i > 15) ? 4'd15 : mag_i[3:0];
        state_d = state_q;
        if (sum_valid) begin
            unique case (state_q)
                ST_NEUTRAL: begin
                    if (avg_i <= -ENTER_TH)     state_d = ST_RIGHT;
                    else if (avg_i >= ENTER_TH) state_d = ST_LEFT;
                end
                ST_RIGHT: begin
                    if (avg_i >= ENTER_TH)      state_d = ST_LEFT;
                    else if (avg_i > -EXIT_TH)  state_d = ST_NEUTRAL;
                end
                ST_LEFT: begin
                    if (avg_i <= -ENTER_TH)     state_d = ST_RIGHT;
                    else if (avg_i < EXIT_TH)   state_d = ST_NEUTRAL;
                end
                default: state_d = ST_NEUTRAL;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_NEUTRAL;
        end else begin
            state_q <= state_d;
        end
    end

    // Registered output decode, refreshed only on a processed sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            tilt_left      <= 1'b0;
            tilt_right     <= 1'b0;
            tilt_intensity <= 4'd0;
            left_leds      <= 4'd0;
            right_leds     <= 4'd0;
            out_valid      <= 1'b0;
        end else begin
            out_valid <= sum_valid;
            if (sum_valid) begin
                tilt_left      <= (state_d == ST_LEFT);
                tilt_right     <= (state_d == ST_RIGHT);
                tilt_intensity <= (state_d == ST_NEUTRAL) ? 4'd0 : mag_sat;
                left_leds      <= (state_d == ST_LEFT)  ? therm_bar(mag_sat) : 4'd0;
                right_leds     <= (state_d == ST_RIGHT) ? therm_bar(mag_sat) : 4'd0;
            end
        end
    end

endmodule

// File: tb/tb_acl_tilt_filter.sv
// Self-checking bench for acl_tilt_filter: directed test-plan steps followed by
// randomized samples and resets, compared every cycle against a window/queue
// reference model of the filter.
module tb_acl_tilt_filter;
    import acl_tilt_filter_pkg::*;

    localparam int AVG_LOG2 = 2;
    localparam int ENTER_TH = 4;
    localparam int EXIT_TH  = 2;
    localparam int DEPTH    = 1 << AVG_LOG2;

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [14:0] acl_data = '0;
    logic        acl_valid = 1'b0;
    logic        tilt_left, tilt_right, out_valid;
    logic [3:0]  tilt_intensity, left_leds, right_leds;

    always #5 clk = ~clk;

    acl_tilt_filter #(
        .AVG_LOG2 (AVG_LOG2),
        .ENTER_TH (ENTER_TH),
        .EXIT_TH  (EXIT_TH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .acl_data       (acl_data),
        .acl_valid      (acl_valid),
        .tilt_left      (tilt_left),
        .tilt_right     (tilt_right),
        .tilt_intensity (tilt_intensity),
        .left_leds      (left_leds),
        .right_leds     (right_leds),
        .out_valid      (out_valid)
    );

    // ---------------- scoreboard counters ----------------
    int errors = 0;
    int checks = 0;
    int pulses = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int          hist_q[$];
    int          m_sum;
    bit          m_s1_valid;
    tilt_state_t m_state;
    bit          m_out_valid, m_left, m_right;
    int          m_int, m_lleds, m_rleds;

    task automatic model_reset();
        hist_q = {};
        for (int i = 0; i < DEPTH; i++) hist_q.push_back(0);
        m_sum = 0;
        m_s1_valid = 0;
        m_state = ST_NEUTRAL;
        m_out_valid = 0; m_left = 0; m_right = 0;
        m_int = 0; m_lleds = 0; m_rleds = 0;
    endtask

    function automatic int floor_avg(input int s);
        int q;
        q = s / DEPTH;
        if ((s % DEPTH != 0) && (s < 0)) q = q - 1;
        return q;
    endfunction

    task automatic model_stage2();
        int avg, mag, sat, steps;
        m_out_valid = m_s1_valid;
        if (m_s1_valid) begin
            avg = floor_avg(m_sum);
            case (m_state)
                ST_NEUTRAL: if (avg <= -ENTER_TH) m_state = ST_RIGHT;
                            else if (avg >= ENTER_TH) m_state = ST_LEFT;
                ST_RIGHT:   if (avg >= ENTER_TH) m_state = ST_LEFT;
                            else if (avg > -EXIT_TH) m_state = ST_NEUTRAL;
                default:    if (avg <= -ENTER_TH) m_state = ST_RIGHT;
                            else if (avg < EXIT_TH) m_state = ST_NEUTRAL;
            endcase
            mag = (avg < 0) ? -avg : avg;
            sat = (mag > 15) ? 15 : mag;
            steps = (sat >= 1) + (sat >= 4) + (sat >= 8) + (sat >= 12);
            m_left  = (m_state == ST_LEFT);
            m_right = (m_state == ST_RIGHT);
            m_int   = (m_left || m_right) ? sat : 0;
            m_lleds = m_left  ? ((1 << steps) - 1) : 0;
            m_rleds = m_right ? ((1 << steps) - 1) : 0;
        end
    endtask

    task automatic model_stage1(input bit v, input int axis);
        m_s1_valid = v;
        if (v) begin
            hist_q.push_back(axis);
            void'(hist_q.pop_front());
            m_sum = 0;
            foreach (hist_q[i]) m_sum += hist_q[i];
        end
    endtask

    // ---------------- driver ----------------
    // Applies inputs for one cycle, advances the model across the edge and
    // compares every observable output 1 time unit after the edge.
    task automatic step(input bit r, input bit v, input int axis);
        logic [4:0] ab;
        int obs_sum;
        ab = axis[4:0];
        rst = r;
        acl_valid = v;
        acl_data = 15'($urandom);
        acl_data[ACL_AXIS_MSB:ACL_AXIS_LSB] = ab;
        @(posedge clk);
        #1;
        if (r) model_reset();
        else begin
            model_stage2();
            model_stage1(v, axis);
        end
        obs_sum = int'(dut.u_avg.sum_q);
        chk("out_valid", 32'(out_valid), 32'(m_out_valid));
        chk("tilt_left", 32'(tilt_left), 32'(m_left));
        chk("tilt_right", 32'(tilt_right), 32'(m_right));
        chk("intensity", 32'(tilt_intensity), 32'(m_int));
        chk("left_leds", 32'(left_leds), 32'(m_lleds));
        chk("right_leds", 32'(right_leds), 32'(m_rleds));
        chk("both_high", 32'(tilt_left & tilt_right), 32'd0);
        chk("sum", 32'(obs_sum), 32'(m_sum));
        chk("state", 32'(dut.state_q), 32'(m_state));
        if (out_valid) pulses++;
    endtask

    task automatic sample_then_wait(input int axis);
        step(0, 1, axis);
        step(0, 0, 0);
        step(0, 0, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int p0;
        model_reset();

        // 1. reset held with a valid sample present
        step(1, 1, -8);
        step(1, 1, -8);
        chk("reset_state", 32'(dut.state_q), 32'(ST_NEUTRAL));
        chk("reset_out_valid", 32'(out_valid), 32'd0);

        // 2. ramp to RIGHT with axis -8
        sample_then_wait(-8);
        chk("ramp1_neutral", 32'(tilt_right), 32'd0);
        sample_then_wait(-8);
        chk("ramp2_right_leds", 32'(right_leds), 32'b0011);
        sample_then_wait(-8);
        sample_then_wait(-8);
        chk("ramp4_intensity", 32'(tilt_intensity), 32'd8);
        chk("ramp4_right_leds", 32'(right_leds), 32'b0111);

        // 3. swing to LEFT with axis +4
        for (int i = 0; i < 4; i++) sample_then_wait(4);
        chk("left_leds_4", 32'(left_leds), 32'b0011);

        // 4. hysteresis at avg +3, then direct swing towards RIGHT
        sample_then_wait(0);
        chk("hyst_left", 32'(tilt_left), 32'd1);
        chk("hyst_intensity", 32'(tilt_intensity), 32'd3);
        for (int i = 0; i < 4; i++) sample_then_wait(-12);

        // 5. saturation
        for (int i = 0; i < 4; i++) sample_then_wait(-16);
        chk("sat_intensity", 32'(tilt_intensity), 32'd15);
        chk("sat_right_leds", 32'(right_leds), 32'b1111);

        // 6. back-to-back samples
        p0 = pulses;
        for (int i = 0; i < 6; i++) step(0, 1, (i % 2 == 0) ? 15 : -16);
        step(0, 0, 0);
        step(0, 0, 0);
        step(0, 0, 0);
        chk("b2b_pulses", 32'(pulses - p0), 32'd6);

        // random traffic with occasional mid-stream resets
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 39) == 0), ($urandom_range(0, 9) < 6),
                 int'($urandom_range(0, 31)) - 16);
        end
        step(0, 0, 0);
        step(0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
